// File: rtl/ca_rule_recovery_if.sv
// Bus between a CA snapshot source and the rule-recovery observer.
//   master: drives ce (sample strobe), clear (sync restart), state_in (snapshot);
//           receives rule, known, complete, conflict, pairs.
//   slave : the observer side; direction of every signal is reversed.
interface ca_rule_recovery_if #(
  parameter int unsigned Width      = 16,
  parameter int unsigned CountWidth = 16
);
  logic                  ce;
  logic                  clear;
  logic [Width-1:0]      state_in;
  logic [7:0]            rule;
  logic [7:0]            known;
  logic                  complete;
  logic                  conflict;
  logic [CountWidth-1:0] pairs;

  modport master (
    output ce, clear, state_in,
    input  rule, known, complete, conflict, pairs
  );

  modport slave (
    input  ce, clear, state_in,
    output rule, known, complete, conflict, pairs
  );
endinterface

// File: rtl/ca_rule_recovery.sv
// Elementary cellular-automaton rule recovery.
// Watches successive snapshots of a cyclic binary CA and rebuilds the 8-bit
// rule from neighbourhood -> next-bit observations.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : ca_rule_recovery_if.slave
//          ce/clear/state_in in; rule/known/complete/conflict/pairs out
// Width and CountWidth must match the parameters of the connected interface.
module ca_rule_recovery #(
  parameter int unsigned Width      = 16,
  parameter int unsigned CountWidth = 16
) (
  input logic               clk,
  input logic               rst,
  ca_rule_recovery_if.slave bus
);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_PRIMED,
    S_LEARN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [Width-1:0]      prev_q, prev_d;
  logic [7:0]            rule_q, rule_d;
  logic [7:0]            known_q, known_d;
  logic                  complete_q, complete_d;
  logic                  conflict_q, conflict_d;
  logic [CountWidth-1:0] pairs_q, pairs_d;

  // Cyclic neighbours of prev: lft[i] = prev[i+1], rgt[i] = prev[i-1].
  logic [Width-1:0] lft, rgt;
  assign lft = {prev_q[0], prev_q[Width-1:1]};
  assign rgt = {prev_q[Width-2:0], prev_q[Width-1]};

  // Per-cell one-hot neighbourhood decode, OR-accumulated along the cells so
  // every index stays a constant and no wide loop index is needed.
  logic [Width:0][7:0] acc1, acc0;
  assign acc1[0] = '0;
  assign acc0[0] = '0;

  for (genvar g = 0; g < Width; g++) begin : g_cell
    logic [2:0] nb;
    logic [7:0] hot;
    assign nb  = {lft[g], prev_q[g], rgt[g]};
    assign hot = 8'(1) << nb;
    assign acc1[g+1] = acc1[g] | (bus.state_in[g] ? hot : '0);
    assign acc0[g+1] = acc0[g] | (bus.state_in[g] ? '0 : hot);
  end

  logic [7:0] one, zero, obs;
  logic [7:0] merged_known, merged_rule;
  logic       bad;

  assign one  = acc1[Width];
  assign zero = acc0[Width];
  assign obs  = one | zero;

  // A neighbourhood seen with both values, or disagreeing with an already
  // known bit, is inconsistent. Where observed, the new value is one[k].
  assign bad          = (|(one & zero)) | (|(known_q & obs & (one ^ rule_q)));
  assign merged_known = known_q | obs;
  assign merged_rule  = (rule_q & ~obs) | one;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    rule_d     = rule_q;
    known_d    = known_q;
    complete_d = complete_q;
    conflict_d = conflict_q;
    pairs_d    = pairs_q;

    if (bus.clear) begin
      state_d    = S_EMPTY;
      prev_d     = '0;
      rule_d     = '0;
      known_d    = '0;
      complete_d = 1'b0;
      conflict_d = 1'b0;
      pairs_d    = '0;
    end else if (bus.ce) begin
      unique case (state_q)
        S_EMPTY: begin
          prev_d  = bus.state_in;
          state_d = S_PRIMED;
        end
        S_PRIMED, S_LEARN, S_DONE: begin
          pairs_d = (pairs_q == '1) ? pairs_q : pairs_q + 1'b1;
          if (bad) begin
            state_d    = S_ERROR;
            conflict_d = 1'b1;
            complete_d = 1'b0;
          end else begin
            prev_d     = bus.state_in;
            rule_d     = merged_rule;
            known_d    = merged_known;
            complete_d = (merged_known == '1);
            state_d    = (merged_known == '1) ? S_DONE : S_LEARN;
          end
        end
        S_ERROR: ;
        default: state_d = S_ERROR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_EMPTY;
      prev_q     <= '0;
      rule_q     <= '0;
      known_q    <= '0;
      complete_q <= 1'b0;
      conflict_q <= 1'b0;
      pairs_q    <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      rule_q     <= rule_d;
      known_q    <= known_d;
      complete_q <= complete_d;
      conflict_q <= conflict_d;
      pairs_q    <= pairs_d;
    end
  end

  assign bus.rule     = rule_q;
  assign bus.known    = known_q;
  assign bus.complete = complete_q;
  assign bus.conflict = conflict_q;
  assign bus.pairs    = pairs_q;

endmodule

// File: tb/tb_ca_rule_recovery.sv
module tb_ca_rule_recovery;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ca_rule_recovery_if #(.Width(16), .CountWidth(16)) bus ();

  ca_rule_recovery #(.Width(16), .CountWidth(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  rule;
    logic [7:0]  known;
    logic        complete;
    logic        conflict;
    logic [15:0] pairs;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: 0 empty, 1 learning, 2 done, 3 error.
  int          mst;
  logic [15:0] mprev;
  logic [15:0] mpairs;
  logic [7:0]  mr, mk;
  logic        mconf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] nxt(input logic [7:0] r, input logic [15:0] s);
    logic [15:0] o;
    logic [2:0]  n;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      n = {s[4'((i + 1) % 16)], s[4'(i)], s[4'((i + 15) % 16)]};
      o[4'(i)] = r[n];
    end
    return o;
  endfunction

  task automatic model_reset();
    mst = 0; mprev = '0; mpairs = '0; mr = '0; mk = '0; mconf = 1'b0;
  endtask

  task automatic model(input logic c, input logic cl, input logic [15:0] d);
    logic [7:0] tk, tr;
    logic       bad;
    logic [2:0] n;
    if (cl) model_reset();
    else if (c) begin
      if (mst == 0) begin
        mprev = d; mst = 1;
      end else if (mst == 1 || mst == 2) begin
        if (mpairs != 16'hFFFF) mpairs = mpairs + 16'd1;
        tk = mk; tr = mr; bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
          n = {mprev[4'((i + 1) % 16)], mprev[4'(i)], mprev[4'((i + 15) % 16)]};
          if (tk[n] && (tr[n] != d[4'(i)])) bad = 1'b1;
          tk[n] = 1'b1;
          tr[n] = d[4'(i)];
        end
        if (bad) begin
          mst = 3; mconf = 1'b1;
        end else begin
          mk = tk; mr = tr; mprev = d;
          mst = (tk == 8'hFF) ? 2 : 1;
        end
      end
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'(sbq.size()), 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk("known",    32'(bus.known),            32'(e.known));
    chk("rule",     32'(bus.rule & bus.known), 32'(e.rule & e.known));
    chk("complete", 32'(bus.complete),         32'(e.complete));
    chk("conflict", 32'(bus.conflict),         32'(e.conflict));
    chk("pairs",    32'(bus.pairs),            32'(e.pairs));
  endtask

  task automatic step(input logic c, input logic cl, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    bus.ce = c; bus.clear = cl; bus.state_in = d;
    model(c, cl, d);
    e.rule = mr; e.known = mk; e.complete = (mst == 2);
    e.conflict = mconf; e.pairs = mpairs;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_out();
    bus.ce = 1'b0; bus.clear = 1'b0;
  endtask

  logic [15:0] s;
  logic [15:0] hold_pairs;

  initial begin
    bus.ce = 1'b0; bus.clear = 1'b0; bus.state_in = '0;
    model_reset();
    #2;
    chk("rst_rule",  32'(bus.rule),  32'd0);
    chk("rst_known", 32'(bus.known), 32'd0);
    chk("rst_pairs", 32'(bus.pairs), 32'd0);
    chk("rst_flags", 32'({bus.complete, bus.conflict}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // One rule-30 step, then continue to 50 steps.
    step(1'b1, 1'b0, 16'h0001);
    step(1'b1, 1'b0, 16'h8003);
    chk("r30_known", 32'(bus.known), 32'h17);
    chk("r30_rk",    32'(bus.rule & bus.known), 32'h16);
    chk("r30_pairs", 32'(bus.pairs), 32'd1);
    chk("r30_flags", 32'({bus.complete, bus.conflict}), 32'd0);
    s = 16'h8003;
    for (int i = 0; i < 49; i++) begin
      s = nxt(8'h1E, s);
      step(1'b1, 1'b0, s);
    end
    chk("r30_done", 32'(bus.complete), 32'd1);
    chk("r30_rule", 32'(bus.rule), 32'h1E);
    chk("r30_conf", 32'(bus.conflict), 32'd0);

    // Rule 90 from a random seed, then a corrupted snapshot.
    step(1'b0, 1'b1, 16'h0000);
    s = 16'($urandom) | 16'h0001;
    step(1'b1, 1'b0, s);
    for (int i = 0; i < 20; i++) begin
      s = nxt(8'h5A, s);
      step(1'b1, 1'b0, s);
    end
    chk("r90_rule", 32'(bus.rule), 32'h5A);
    chk("r90_done", 32'(bus.complete), 32'd1);
    s = nxt(8'h5A, s) ^ 16'h0010;
    step(1'b1, 1'b0, s);
    chk("r90_conf",  32'(bus.conflict), 32'd1);
    chk("r90_cmpl",  32'(bus.complete), 32'd0);
    chk("r90_keep",  32'(bus.rule), 32'h5A);
    hold_pairs = bus.pairs;
    step(1'b1, 1'b0, 16'h1234);
    step(1'b1, 1'b0, 16'h4321);
    chk("err_frozen", 32'(bus.pairs), 32'(hold_pairs));
    chk("err_sticky", 32'(bus.conflict), 32'd1);

    // All-zero stream, with a ce=0 hold in between.
    step(1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'hFFFF);
    step(1'b1, 1'b0, 16'h0000);
    chk("zero_known", 32'(bus.known), 32'h01);
    chk("zero_rule0", 32'(bus.rule[0]), 32'd0);
    chk("zero_pairs", 32'(bus.pairs), 32'd2);
    chk("zero_cmpl",  32'(bus.complete), 32'd0);

    // Wrap-around: a true rule-2 step 8000 -> 0001 (cell 0 sees cell 15).
    step(1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 16'h8000);
    step(1'b1, 1'b0, 16'h0001);
    chk("wrap_known", 32'(bus.known), 32'h17);
    chk("wrap_rk",    32'(bus.rule & bus.known), 32'h02);

    // clear with ce mid-learning, then async reset between edges.
    step(1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 16'h0001);
    step(1'b1, 1'b0, 16'h8003);
    step(1'b1, 1'b1, 16'h4005);
    chk("clr_pairs", 32'(bus.pairs), 32'd0);
    chk("clr_known", 32'(bus.known), 32'd0);
    step(1'b1, 1'b0, 16'h0001);
    step(1'b1, 1'b0, 16'h8003);
    chk("pre_rst_pairs", 32'(bus.pairs), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_known", 32'(bus.known), 32'd0);
    chk("arst_rule",  32'(bus.rule),  32'd0);
    chk("arst_pairs", 32'(bus.pairs), 32'd0);
    model_reset();
    rst = 1'b1;
    step(1'b1, 1'b0, 16'h8003);
    chk("prime_pairs", 32'(bus.pairs), 32'd0);
    step(1'b1, 1'b0, 16'h0001);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
